vga_pixel_fetch: RTL and testbench
==================================

Name: vga_pixel_fetch

Overview:
- Prefetch engine between the frame memory (192-bit words, 6 lanes of 32 bits) and the VGA colour outputs.
- Streams image words into a small FIFO ahead of the raster, unpacks two RGB pixels per word and presents registered 8-bit r/g/b aligned to the pixel strobe.
- Replaces the direct per-pixel address calculation at the VGA output; sync generation stays upstream.

Parameters:
- V, 192, memory word width (6 lanes).
- S, 32, lane/address width.
- IMG_W, 100, active image width in pixels (must be even).
- IMG_H, 100, active image height in pixels.
- BASE_ADDR, 0, word address of the first image word.
- ADDR_STEP, 1, address increment per word.
- FIFO_DEPTH, 4, FIFO entries (power of two, min 2).

Ports:
- clk  in  1  system clock 50 MHz
- rst  in  1  asynchronous reset, active-low
- pix_tick  in  1  one-clk strobe per pixel (25 MHz rate)
- frame_start  in  1  one-clk pulse at start of vertical blanking
- video_on  in  1  raster inside visible area
- x  in  10  current pixel column
- y  in  10  current pixel row
- mem_req  out  1  read request
- mem_addr  out  S  word address, held stable while mem_req=1
- mem_ack  in  1  one-clk acknowledge; mem_rdata valid in the same cycle
- mem_rdata  in  V  word read
- r  out  8  red
- g  out  8  green
- b  out  8  blue
- underflow  out  1  sticky: pixel needed while FIFO empty

Behaviour:
- Word layout: lanes 0,1,2 (bits [7:0], [39:32], [71:64]) = R,G,B of even pixel; lanes 3,4,5 (bits [103:96], [135:128], [167:160]) = R,G,B of following odd pixel. Upper 24 bits of each lane ignored.
- Words per frame: NWORDS = IMG_W*IMG_H/2 (5000 default); pixels in raster order.
- Reset (rst=0, async): r=g=b=0, mem_req=0, mem_addr=BASE_ADDR, underflow=0, FIFO empty, word counter 0, half-select 0, FSM IDLE.
- Fetch FSM:
  - IDLE: wait for frame_start, then go to FETCH.
  - FETCH: if FIFO count < FIFO_DEPTH, assert mem_req and go to WAIT.
  - WAIT: mem_req held high with mem_addr stable until mem_ack. On ack, push mem_rdata, mem_addr += ADDR_STEP, and word counter increments. Go to DONE if counter reaches NWORDS, else FETCH.
  - DONE: mem_req=0 until frame_start.
- At most one outstanding request. Pushing is never blocked, because a request is only issued when a slot is free.
- frame_start in any state, including simultaneously with mem_ack:
  - Next cycle: FIFO flushed, acked data discarded, mem_req=0, mem_addr=BASE_ADDR, counter=0, half-select=0, FSM to FETCH.
  - underflow is not cleared.
  - Memory side must tolerate a withdrawn request.
- Pixel path, evaluated only on pix_tick cycles; outputs registered, visible the clk after pix_tick.
  - video_on=1, x<IMG_W, y<IMG_H, FIFO non-empty:
    - Output lanes 0-2 of the head word if half-select=0, else lanes 3-5.
    - Toggle half-select. Pop the head word when half-select was 1.
  - Same condition with FIFO empty: r=g=b=0, underflow set, half-select and FIFO unchanged (pixel skipped, not dropped).
  - Otherwise: r=g=b=0, no FIFO change.
- Pop and push in the same cycle are both performed; count unchanged.
- Without pix_tick, r/g/b hold their value.
- underflow clears only on reset.

Test Plan:
- Reset then frame_start: mem_req rises within 2 clk with mem_addr=0. Ack 4 words with no pix_tick → requests stop with count=4 and mem_addr=4.
- Word with lanes 0..5 = 0x11,0x22,0x33,0x44,0x55,0x66, then pix_tick at x=0,y=0 and x=1,y=0 (video_on=1) → r/g/b = 11/22/33, then 44/55/66. FIFO pops once.
- pix_tick at x=150, video_on=1 → r=g=b=0, FIFO count unchanged.
- Ack withheld and FIFO emptied, then pix_tick in image area → r=g=b=0 and underflow=1. underflow stays 1 after the FIFO refills.
- Full frame with immediate ack → exactly 5000 acks, last mem_addr=4999, FSM DONE, mem_req=0.
- frame_start asserted in the same cycle as mem_ack at mem_addr=37 → data not pushed, FIFO empty, next request at mem_addr=0.

Source files
------------

// File: rtl/vga_pixel_fetch_if.sv
// Frame-memory read bus used by the VGA pixel prefetch engine.
// One outstanding request; the slave answers with a one-clk ack and data in that same cycle.
interface vga_pixel_fetch_if #(
    parameter int V = 192,
    parameter int S = 32
);
    logic         mem_req;
    logic [S-1:0] mem_addr;
    logic         mem_ack;
    logic [V-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/vga_pixel_fetch.sv
// VGA pixel prefetch engine: streams image words from frame memory into a small FIFO
// ahead of the raster and unpacks two RGB pixels per word onto registered r/g/b outputs.
module vga_pixel_fetch #(
    parameter int V          = 192,
    parameter int S          = 32,
    parameter int IMG_W      = 100,
    parameter int IMG_H      = 100,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_STEP  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_tick,
    input  logic                 frame_start,
    input  logic                 video_on,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    vga_pixel_fetch_if.master    mem,
    output logic [7:0]           r,
    output logic [7:0]           g,
    output logic [7:0]           b,
    output logic                 underflow
);

    localparam int               NWORDS  = IMG_W * IMG_H / 2;
    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [9:0]       IMG_W_C = 10'(IMG_W);
    localparam logic [9:0]       IMG_H_C = 10'(IMG_H);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               memReq_q, memReq_d;
    logic [S-1:0]       memAddr_q, memAddr_d;
    logic [31:0]        wordCnt_q, wordCnt_d;
    logic               push, pop, flush;

    // Only the 8-bit colour of each lane is kept: {B1,G1,R1,B0,G0,R0}, R0 in the low byte.
    logic [47:0]        fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, rdPtr_q;
    logic [PTR_W:0]     count_q;
    logic [47:0]        pushWord;
    logic [47:0]        headWord;

    logic               half_q, half_d;
    logic               underflow_q, underflow_d;
    logic [7:0]         pixR_q, pixR_d, pixG_q, pixG_d, pixB_q, pixB_d;
    logic               inImage;
    logic               unusedLaneBits;

    assign pushWord = {mem.mem_rdata[167:160], mem.mem_rdata[135:128], mem.mem_rdata[103:96],
                       mem.mem_rdata[71:64],   mem.mem_rdata[39:32],   mem.mem_rdata[7:0]};
    assign unusedLaneBits = ^{mem.mem_rdata[191:168], mem.mem_rdata[159:136], mem.mem_rdata[127:104],
                              mem.mem_rdata[95:72],   mem.mem_rdata[63:40],   mem.mem_rdata[31:8]};
    assign headWord = fifoMem_q[rdPtr_q];
    assign inImage  = video_on && (x < IMG_W_C) && (y < IMG_H_C);

    // Fetch FSM next state: one request at a time, only when a FIFO slot is free; frame_start restarts everything.
    always_comb begin
        state_d   = state_q;
        memReq_d  = memReq_q;
        memAddr_d = memAddr_q;
        wordCnt_d = wordCnt_q;
        push      = 1'b0;
        flush     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                memReq_d = 1'b0;
            end
            ST_FETCH: begin
                if (count_q < DEPTH_C) begin
                    memReq_d = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem.mem_ack) begin
                    push      = 1'b1;
                    memReq_d  = 1'b0;
                    memAddr_d = memAddr_q + S'(ADDR_STEP);
                    wordCnt_d = wordCnt_q + 32'd1;
                    state_d   = (wordCnt_q + 32'd1 == 32'(NWORDS)) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                memReq_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
        if (frame_start) begin
            state_d   = ST_FETCH;
            memReq_d  = 1'b0;
            memAddr_d = S'(BASE_ADDR);
            wordCnt_d = '0;
            push      = 1'b0;
            flush     = 1'b1;
        end
    end

    // Pixel path: on each pixel strobe pick the head word's half, or blank; an empty FIFO in the image skips the pixel.
    always_comb begin
        pixR_d      = pixR_q;
        pixG_d      = pixG_q;
        pixB_d      = pixB_q;
        half_d      = half_q;
        underflow_d = underflow_q;
        pop         = 1'b0;
        if (pix_tick) begin
            pixR_d = 8'h00;
            pixG_d = 8'h00;
            pixB_d = 8'h00;
            if (inImage) begin
                if (count_q != '0) begin
                    if (half_q) begin
                        pixR_d = headWord[31:24];
                        pixG_d = headWord[39:32];
                        pixB_d = headWord[47:40];
                    end else begin
                        pixR_d = headWord[7:0];
                        pixG_d = headWord[15:8];
                        pixB_d = headWord[23:16];
                    end
                    half_d = ~half_q;
                    pop    = half_q;
                end else begin
                    underflow_d = 1'b1;
                end
            end
        end
        if (flush) begin
            half_d = 1'b0;
        end
    end

    // Control registers: FSM, request/address, counters, FIFO pointers and registered colour outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            memReq_q    <= 1'b0;
            memAddr_q   <= S'(BASE_ADDR);
            wordCnt_q   <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            half_q      <= 1'b0;
            underflow_q <= 1'b0;
            pixR_q      <= 8'h00;
            pixG_q      <= 8'h00;
            pixB_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            memReq_q    <= memReq_d;
            memAddr_q   <= memAddr_d;
            wordCnt_q   <= wordCnt_d;
            half_q      <= half_d;
            underflow_q <= underflow_d;
            pixR_q      <= pixR_d;
            pixG_q      <= pixG_d;
            pixB_q      <= pixB_d;
            if (flush) begin
                wrPtr_q <= '0;
                rdPtr_q <= '0;
                count_q <= '0;
            end else begin
                if (push) wrPtr_q <= wrPtr_q + 1'b1;
                if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // FIFO storage needs no reset: the count and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) fifoMem_q[wrPtr_q] <= pushWord;
    end

    assign mem.mem_req  = memReq_q;
    assign mem.mem_addr = memAddr_q;
    assign r            = pixR_q;
    assign g            = pixG_q;
    assign b            = pixB_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Self-checking bench for vga_pixel_fetch: directed vector table for the pixel path plus
// sequences for fetch start, refill after underflow, a full frame and frame_start colliding with an ack.
module tb_vga_pixel_fetch;

    logic       clk;
    logic       rst;
    logic       pix_tick;
    logic       frame_start;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] r, g, b;
    logic       underflow;

    vga_pixel_fetch_if #(.V(192), .S(32)) mem ();

    vga_pixel_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .pix_tick    (pix_tick),
        .frame_start (frame_start),
        .video_on    (video_on),
        .x           (x),
        .y           (y),
        .mem         (mem),
        .r           (r),
        .g           (g),
        .b           (b),
        .underflow   (underflow)
    );

    typedef struct {
        string      name;
        bit         tick;
        bit         vo;
        int         px;
        int         py;
        logic [7:0] er;
        logic [7:0] eg;
        logic [7:0] eb;
        bit         euf;
        int         ecnt;
    } vec_t;

    int           total;
    int           bad;
    int           ackCount;
    logic [31:0]  lastAckAddr;
    bit           autoAck;
    bit           useManual;
    logic [191:0] manualWords [4];
    bit           rasterOn;
    bit           pixPhase;
    int           rasterX;
    int           rasterY;
    bit           checkPix;
    bit           pend;
    int           pendIdx;
    int           pixErr;

    // 50 MHz system clock.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Lane colour byte of the generated word at address a.
    function automatic logic [7:0] laneVal(input logic [31:0] a, input int lane);
        case (lane)
            0:       laneVal = a[7:0];
            1:       laneVal = a[15:8] + 8'h31;
            2:       laneVal = a[7:0] ^ 8'hA5;
            3:       laneVal = ~a[7:0];
            4:       laneVal = a[7:0] + 8'h5C;
            default: laneVal = a[12:5];
        endcase
    endfunction

    // Word built from six lane bytes, with junk in each lane's upper 24 bits.
    function automatic logic [191:0] makeWord(input logic [47:0] lanes);
        logic [191:0] w;
        w = '0;
        for (int i = 0; i < 6; i++) begin
            w[i*32 +: 32] = {24'hF0E1D2, lanes[i*8 +: 8]};
        end
        return w;
    endfunction

    function automatic logic [191:0] wordFor(input logic [31:0] a);
        logic [47:0] l;
        for (int i = 0; i < 6; i++) l[i*8 +: 8] = laneVal(a, i);
        return makeWord(l);
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: check any pending pixel, then drive memory responder and raster for the next cycle.
    task automatic applyStimulus();
        logic [31:0] a;
        int          lb;
        @(negedge clk);
        if (pend) begin
            a  = 32'(pendIdx / 2);
            lb = (pendIdx % 2) * 3;
            if ({r, g, b} !== {laneVal(a, lb), laneVal(a, lb + 1), laneVal(a, lb + 2)}) pixErr++;
            pend = 1'b0;
        end
        frame_start = 1'b0;
        pix_tick    = 1'b0;
        if (autoAck && mem.mem_req && !mem.mem_ack) begin
            mem.mem_ack   = 1'b1;
            mem.mem_rdata = (useManual && mem.mem_addr < 4) ? manualWords[mem.mem_addr[1:0]] : wordFor(mem.mem_addr);
            ackCount++;
            lastAckAddr = mem.mem_addr;
        end else begin
            mem.mem_ack = 1'b0;
        end
        if (rasterOn) begin
            pixPhase = ~pixPhase;
            if (pixPhase) begin
                pix_tick = 1'b1;
                video_on = 1'b1;
                x        = 10'(rasterX);
                y        = 10'(rasterY);
                if (checkPix) begin
                    pend    = 1'b1;
                    pendIdx = rasterY * 100 + rasterX;
                end
                rasterX++;
                if (rasterX == 100) begin
                    rasterX = 0;
                    rasterY++;
                end
                if (rasterY == 100) rasterOn = 1'b0;
            end
        end
    endtask

    task automatic resetDut();
        rst      = 1'b0;
        autoAck  = 1'b0;
        rasterOn = 1'b0;
        checkPix = 1'b0;
        pend     = 1'b0;
        video_on = 1'b0;
        x        = '0;
        y        = '0;
        applyStimulus();
        applyStimulus();
        rst      = 1'b1;
        ackCount = 0;
        pixErr   = 0;
        pixPhase = 1'b0;
        rasterX  = 0;
        rasterY  = 0;
        applyStimulus();
    endtask

    // Compares all observable pixel-path state against one table record.
    task automatic checkOutput(input vec_t v);
        checkVal({v.name, ".rgb"}, {40'h0, r, g, b}, {40'h0, v.er, v.eg, v.eb});
        checkVal({v.name, ".uf"}, 64'(underflow), 64'(v.euf));
        checkVal({v.name, ".cnt"}, 64'(dut.count_q), 64'(v.ecnt));
    endtask

    vec_t vecs [15];

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b0;
        pix_tick      = 1'b0;
        frame_start   = 1'b0;
        video_on      = 1'b0;
        x             = '0;
        y             = '0;
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = '0;
        useManual     = 1'b1;
        lastAckAddr   = '0;
        manualWords[0] = makeWord(48'h66_55_44_33_22_11);
        manualWords[1] = makeWord(48'hCC_BB_AA_99_88_77);
        manualWords[2] = makeWord(48'h06_05_04_03_02_01);
        manualWords[3] = makeWord(48'hA6_A5_A4_A3_A2_A1);

        vecs[0]  = '{"pix0",  1, 1,   0,   0, 8'h11, 8'h22, 8'h33, 0, 4};
        vecs[1]  = '{"pix1",  1, 1,   1,   0, 8'h44, 8'h55, 8'h66, 0, 3};
        vecs[2]  = '{"hold",  0, 1,   1,   0, 8'h44, 8'h55, 8'h66, 0, 3};
        vecs[3]  = '{"xOut",  1, 1, 150,   0, 8'h00, 8'h00, 8'h00, 0, 3};
        vecs[4]  = '{"blank", 1, 0,   2,   0, 8'h00, 8'h00, 8'h00, 0, 3};
        vecs[5]  = '{"pix2",  1, 1,   2,   0, 8'h77, 8'h88, 8'h99, 0, 3};
        vecs[6]  = '{"yOut",  1, 1,   3, 120, 8'h00, 8'h00, 8'h00, 0, 3};
        vecs[7]  = '{"pix3",  1, 1,   3,   0, 8'hAA, 8'hBB, 8'hCC, 0, 2};
        vecs[8]  = '{"pix4",  1, 1,   4,   0, 8'h01, 8'h02, 8'h03, 0, 2};
        vecs[9]  = '{"pix5",  1, 1,   5,   0, 8'h04, 8'h05, 8'h06, 0, 1};
        vecs[10] = '{"pix6",  1, 1,   6,   0, 8'hA1, 8'hA2, 8'hA3, 0, 1};
        vecs[11] = '{"pix7",  1, 1,   7,   0, 8'hA4, 8'hA5, 8'hA6, 0, 0};
        vecs[12] = '{"under", 1, 1,   8,   0, 8'h00, 8'h00, 8'h00, 1, 0};
        vecs[13] = '{"retry", 1, 1,   8,   0, 8'h00, 8'h00, 8'h00, 1, 0};
        vecs[14] = '{"idle",  0, 1,   8,   0, 8'h00, 8'h00, 8'h00, 1, 0};

        // Reset state.
        resetDut();
        checkVal("rst.req", 64'(mem.mem_req), 64'd0);
        checkVal("rst.addr", 64'(mem.mem_addr), 64'd0);
        checkVal("rst.rgb", 64'({r, g, b}), 64'd0);
        checkVal("rst.uf", 64'(underflow), 64'd0);
        checkVal("rst.state", 64'(dut.state_q), 64'd0);

        // Start of frame: request appears two clocks later at the base address.
        frame_start = 1'b1;
        applyStimulus();
        applyStimulus();
        checkVal("start.req", 64'(mem.mem_req), 64'd1);
        checkVal("start.addr", 64'(mem.mem_addr), 64'd0);

        // Fill the FIFO with no pixel demand: fetching stalls at four words.
        autoAck = 1'b1;
        for (int i = 0; i < 30; i++) applyStimulus();
        autoAck = 1'b0;
        applyStimulus();
        checkVal("fill.acks", 64'(ackCount), 64'd4);
        checkVal("fill.cnt", 64'(dut.count_q), 64'd4);
        checkVal("fill.addr", 64'(mem.mem_addr), 64'd4);
        checkVal("fill.req", 64'(mem.mem_req), 64'd0);

        // Pixel path vectors with memory acks withheld.
        for (int i = 0; i < 15; i++) begin
            pix_tick = vecs[i].tick;
            video_on = vecs[i].vo;
            x        = 10'(vecs[i].px);
            y        = 10'(vecs[i].py);
            applyStimulus();
            checkOutput(vecs[i]);
        end

        // Refill after underflow: the flag stays sticky.
        autoAck = 1'b1;
        for (int i = 0; i < 30; i++) applyStimulus();
        autoAck = 1'b0;
        applyStimulus();
        checkVal("refill.cnt", 64'(dut.count_q), 64'd4);
        checkVal("refill.uf", 64'(underflow), 64'd1);

        // Full frame with immediate acks and every pixel checked.
        useManual = 1'b0;
        resetDut();
        frame_start = 1'b1;
        autoAck     = 1'b1;
        for (int i = 0; i < 20; i++) applyStimulus();
        checkPix = 1'b1;
        rasterOn = 1'b1;
        for (int i = 0; i < 30000 && (rasterOn || pend); i++) applyStimulus();
        checkVal("frame.timeout", 64'(rasterOn || pend), 64'd0);
        for (int i = 0; i < 4; i++) applyStimulus();
        checkVal("frame.acks", 64'(ackCount), 64'd5000);
        checkVal("frame.lastAddr", 64'(lastAckAddr), 64'd4999);
        checkVal("frame.state", 64'(dut.state_q), 64'd3);
        checkVal("frame.req", 64'(mem.mem_req), 64'd0);
        checkVal("frame.pixels", 64'(pixErr), 64'd0);
        checkVal("frame.uf", 64'(underflow), 64'd0);

        // frame_start colliding with the ack of word 37: data dropped and fetch restarts at base.
        checkPix = 1'b0;
        resetDut();
        frame_start = 1'b1;
        autoAck     = 1'b1;
        rasterOn    = 1'b1;
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 3000 && !hit; i++) begin
                applyStimulus();
                if (mem.mem_ack && lastAckAddr == 32'd37) hit = 1'b1;
            end
            checkVal("collide.reached", 64'(hit), 64'd1);
        end
        frame_start = 1'b1;
        autoAck     = 1'b0;
        rasterOn    = 1'b0;
        video_on    = 1'b0;
        applyStimulus();
        checkVal("collide.cnt", 64'(dut.count_q), 64'd0);
        checkVal("collide.req", 64'(mem.mem_req), 64'd0);
        checkVal("collide.addr", 64'(mem.mem_addr), 64'd0);
        checkVal("collide.state", 64'(dut.state_q), 64'd1);
        applyStimulus();
        checkVal("restart.req", 64'(mem.mem_req), 64'd1);
        checkVal("restart.addr", 64'(mem.mem_addr), 64'd0);
        checkVal("restart.cnt", 64'(dut.count_q), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
